// File: rtl/branch_resolve_unit.sv
// Branch resolution in EX: carries the fetch prediction through ID/EX, checks it
// against the actual outcome, and trains a table of 2-bit direction counters.
module branch_resolve_unit #(
   parameter int BHT_ENTRIES = 64,
   parameter int BHT_IDX_W   = 6,
   parameter int MISS_CNT_W  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  if_flush,
   input  logic                  if_valid,
   input  logic                  if_is_branch,
   input  logic [31:0]           if_pc,
   input  logic [31:0]           if_target,
   input  logic                  if_prediction,
   input  logic [31:0]           ex_rs_data,
   input  logic [31:0]           ex_rt_data,
   input  logic                  ex_branch_type,
   input  logic [31:0]           lookup_pc,
   output logic                  lookup_taken,
   output logic                  branch_sig,
   output logic                  hit,
   output logic [31:0]           miss_address,
   output logic [MISS_CNT_W-1:0] miss_count
);

   typedef struct packed {
      logic        valid;
      logic        is_branch;
      logic [31:0] pc;
      logic [31:0] target;
      logic        prediction;
   } slot_t;

   slot_t                d_slot;
   slot_t                e_slot;
   logic [1:0]           bht [BHT_ENTRIES];
   logic                 eq;
   logic                 actual;
   logic                 mispredict;
   logic [BHT_IDX_W-1:0] upd_idx;
   logic                 unused_lookup_hi;

   assign upd_idx          = e_slot.pc[BHT_IDX_W-1:0];
   assign unused_lookup_hi = ^lookup_pc[31:BHT_IDX_W];

   // Plain read of the registered table: an update this cycle shows up next cycle.
   assign lookup_taken = bht[lookup_pc[BHT_IDX_W-1:0]][1];

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      eq           = (ex_rs_data == ex_rt_data);
      actual       = ex_branch_type ? ~eq : eq;
      branch_sig   = e_slot.valid & e_slot.is_branch & ~stall;
      hit          = branch_sig & (actual == e_slot.prediction);
      mispredict   = branch_sig & ~hit;
      miss_address = '0;
      if (branch_sig)
         miss_address = actual ? e_slot.target : e_slot.pc + 32'd1;
   end

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         d_slot     <= '0;
         e_slot     <= '0;
         miss_count <= '0;
         // NOTE: the table is reset because prediction must start from a known weakly-not-taken state.
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= 2'b01;
      end else begin
         if (mispredict) begin
            // Wrong-path work in D and the IF entry on this edge is discarded.
            d_slot <= '0;
            e_slot <= '0;
         end else if (!stall) begin
            e_slot <= d_slot;
            d_slot <= '{valid:      if_valid & ~if_flush,
                        is_branch:  if_is_branch,
                        pc:         if_pc,
                        target:     if_target,
                        prediction: if_prediction};
         end

         if (branch_sig) begin
            if (actual) begin
               if (bht[upd_idx] != 2'b11)
                  bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else if (bht[upd_idx] != 2'b00) begin
               bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
         end

         if (mispredict && (miss_count != {MISS_CNT_W{1'b1}}))
            miss_count <= miss_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: scenario tasks with hand-computed expectations.
module tb_branch_resolve_unit;

   logic        clock = 1'b0;
   logic        reset, stall, if_flush, if_valid, if_is_branch, if_prediction;
   logic [31:0] if_pc, if_target, ex_rs_data, ex_rt_data, lookup_pc;
   logic        ex_branch_type;
   logic        lookup_taken, branch_sig, hit;
   logic [31:0] miss_address;
   logic [15:0] miss_count;

   int checks = 0;
   int errors = 0;

   branch_resolve_unit #(.BHT_ENTRIES(64), .BHT_IDX_W(6), .MISS_CNT_W(16)) dut (
      .clock(clock), .reset(reset), .stall(stall), .if_flush(if_flush),
      .if_valid(if_valid), .if_is_branch(if_is_branch), .if_pc(if_pc),
      .if_target(if_target), .if_prediction(if_prediction),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_branch_type(ex_branch_type), .lookup_pc(lookup_pc),
      .lookup_taken(lookup_taken), .branch_sig(branch_sig), .hit(hit),
      .miss_address(miss_address), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic present_if(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic pred);
      if_valid      = v;
      if_is_branch  = v;
      if_pc         = pc;
      if_target     = tgt;
      if_prediction = pred;
   endtask

   task automatic set_ex(input logic [31:0] rs, input logic [31:0] rt, input logic bt);
      ex_rs_data     = rs;
      ex_rt_data     = rt;
      ex_branch_type = bt;
      #1;
   endtask

   // Branch enters IF, reaches E two edges later; operands applied, verdict left visible.
   task automatic send_branch(input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                              input logic [31:0] rs, input logic [31:0] rt, input logic bt);
      present_if(1'b1, pc, tgt, pred);
      step();
      present_if(1'b0, 32'h0, 32'h0, 1'b0);
      step();
      set_ex(rs, rt, bt);
   endtask

   task automatic check_verdict(input string name, input logic exp_bs, input logic exp_hit,
                                input logic [31:0] exp_ma);
      checks++;
      if (branch_sig !== exp_bs || hit !== exp_hit || miss_address !== exp_ma) begin
         errors++;
         $display("FAIL %s: got bs=%0b hit=%0b ma=%h, want bs=%0b hit=%0b ma=%h",
                  name, branch_sig, hit, miss_address, exp_bs, exp_hit, exp_ma);
      end
   endtask

   task automatic check_lookup(input string name, input logic [31:0] pc, input logic exp);
      lookup_pc = pc;
      #1;
      checks++;
      if (lookup_taken !== exp) begin
         errors++;
         $display("FAIL %s: lookup_taken(%h) got %0b want %0b", name, pc, lookup_taken, exp);
      end
   endtask

   task automatic check_misses(input string name, input logic [15:0] exp);
      checks++;
      if (miss_count !== exp) begin
         errors++;
         $display("FAIL %s: miss_count got %0d want %0d", name, miss_count, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 64; i++) begin
         lookup_pc = i;
         #1;
         checks++;
         if (lookup_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_bht[%0d]: got %0b want 0", i, lookup_taken);
         end
      end
      check_misses("reset_miss_count", 16'd0);
      check_verdict("reset_outputs", 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_mispredict_taken();
      present_if(1'b1, 32'h10, 32'h40, 1'b0);
      step();
      present_if(1'b1, 32'h30, 32'h77, 1'b0);
      step();
      present_if(1'b1, 32'h31, 32'h88, 1'b0);
      set_ex(32'd5, 32'd5, 1'b0);
      check_verdict("miss_taken_verdict", 1'b1, 1'b0, 32'h40);
      check_lookup("miss_taken_pre_update", 32'h10, 1'b0);
      step();
      present_if(1'b0, 32'h0, 32'h0, 1'b0);
      check_verdict("miss_taken_e_flushed", 1'b0, 1'b0, 32'h0);
      check_misses("miss_taken_count", 16'd1);
      check_lookup("miss_taken_bht", 32'h10, 1'b1);
      step();
      check_verdict("miss_taken_d_flushed", 1'b0, 1'b0, 32'h0);
      step();
      check_verdict("miss_taken_if_dropped", 1'b0, 1'b0, 32'h0);
      check_lookup("miss_taken_bht_30", 32'h30, 1'b0);
   endtask

   task automatic test_bne_not_taken();
      send_branch(32'h20, 32'h99, 1'b1, 32'd7, 32'd7, 1'b1);
      check_verdict("bne_verdict", 1'b1, 1'b0, 32'h21);
      step();
      check_misses("bne_count", 16'd2);
      check_lookup("bne_bht_00", 32'h20, 1'b0);
      for (int i = 0; i < 4; i++) begin
         send_branch(32'h20, 32'h99, 1'b0, 32'd7, 32'd7, 1'b1);
         check_verdict("bne_repeat_hit", 1'b1, 1'b1, 32'h21);
         step();
      end
      check_misses("bne_repeat_count", 16'd2);
      check_lookup("bne_bht_saturated", 32'h20, 1'b0);
      // One taken resolution from 00 must only reach 01, still reading not-taken.
      send_branch(32'h20, 32'h99, 1'b0, 32'd7, 32'd8, 1'b1);
      step();
      check_lookup("bne_bht_from_floor", 32'h20, 1'b0);
      check_misses("bne_after_taken", 16'd3);
   endtask

   task automatic test_hit();
      present_if(1'b1, 32'h08, 32'h55, 1'b0);
      step();
      present_if(1'b1, 32'h0C, 32'h70, 1'b1);
      step();
      present_if(1'b0, 32'h0, 32'h0, 1'b0);
      set_ex(32'd1, 32'd2, 1'b0);
      check_verdict("hit_verdict", 1'b1, 1'b1, 32'h09);
      step();
      set_ex(32'd3, 32'd3, 1'b0);
      check_verdict("hit_next_advanced", 1'b1, 1'b1, 32'h70);
      step();
      check_verdict("hit_drained", 1'b0, 1'b0, 32'h0);
      check_misses("hit_count", 16'd3);
      check_lookup("hit_bht_08", 32'h08, 1'b0);
      check_lookup("hit_bht_0c", 32'h0C, 1'b1);
   endtask

   task automatic test_stall();
      send_branch(32'h18, 32'h60, 1'b0, 32'd4, 32'd4, 1'b0);
      stall    = 1'b1;
      if_flush = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_verdict("stall_no_resolve", 1'b0, 1'b0, 32'h0);
         step();
      end
      check_misses("stall_count_held", 16'd3);
      check_lookup("stall_bht_held", 32'h18, 1'b0);
      stall    = 1'b0;
      if_flush = 1'b0;
      #1;
      check_verdict("stall_release", 1'b1, 1'b0, 32'h60);
      step();
      check_verdict("stall_once_only", 1'b0, 1'b0, 32'h0);
      check_misses("stall_count", 16'd4);
      check_lookup("stall_bht_once", 32'h18, 1'b1);
   endtask

   task automatic test_flush();
      if_flush = 1'b1;
      present_if(1'b1, 32'h28, 32'h90, 1'b0);
      step();
      if_flush = 1'b0;
      present_if(1'b0, 32'h0, 32'h0, 1'b0);
      step();
      set_ex(32'd6, 32'd6, 1'b0);
      check_verdict("flush_no_resolve", 1'b0, 1'b0, 32'h0);
      step();
      check_misses("flush_count", 16'd4);
      check_lookup("flush_bht", 32'h28, 1'b0);
   endtask

   task automatic test_pc_wrap();
      send_branch(32'hFFFF_FFFF, 32'h1234, 1'b1, 32'd1, 32'd2, 1'b0);
      check_verdict("wrap_verdict", 1'b1, 1'b0, 32'h0000_0000);
      step();
      check_misses("wrap_count", 16'd5);
      check_lookup("wrap_bht_3f", 32'h3F, 1'b0);
   endtask

   task automatic test_reset_mid();
      send_branch(32'h04, 32'h44, 1'b0, 32'd9, 32'd9, 1'b0);
      check_verdict("rst_mid_pending", 1'b1, 1'b0, 32'h44);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check_verdict("rst_mid_discarded", 1'b0, 1'b0, 32'h0);
      check_misses("rst_mid_count", 16'd0);
      check_lookup("rst_mid_bht_04", 32'h04, 1'b0);
      check_lookup("rst_mid_bht_10", 32'h10, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      stall     = 1'b0;
      if_flush  = 1'b0;
      lookup_pc = 32'h0;
      present_if(1'b0, 32'h0, 32'h0, 1'b0);
      ex_rs_data     = 32'h0;
      ex_rt_data     = 32'h1;
      ex_branch_type = 1'b0;
      test_reset();
      test_mispredict_taken();
      test_bne_not_taken();
      test_hit();
      test_stall();
      test_flush();
      test_pc_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves conditional branches in EX and returns the verdict to the fetch stage's jump unit.
- Captures the fetch-time prediction tag (pc, target, predicted direction) and carries it through an ID/EX shadow pipeline.
- In EX, compares the prediction with the actual outcome and drives the branch-signal, hit and miss-address inputs of fetch.
- Owns a table of 2-bit saturating direction counters, which fetch reads through a lookup port, plus a misprediction statistics counter.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of two.
- BHT_IDX_W, 6, log2(BHT_ENTRIES); index = pc[BHT_IDX_W-1:0].
- MISS_CNT_W, 16, width of the misprediction counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  pipeline freeze from hazard unit
- if_flush  in  1  fetch's flush; kills the instruction currently in IF
- if_valid  in  1  IF slot holds a real instruction
- if_is_branch  in  1  IF instruction is a conditional branch
- if_pc  in  32  word address of the IF instruction
- if_target  in  32  branch target computed in fetch
- if_prediction  in  1  direction fetch used (1 = taken)
- ex_rs_data  in  32  EX operand A
- ex_rt_data  in  32  EX operand B
- ex_branch_type  in  1  0 = beq, 1 = bne
- lookup_pc  in  32  fetch's PC for the direction query
- lookup_taken  out  1  counter[1] of the entry at lookup_pc
- branch_sig  out  1  a branch is resolved this cycle
- hit  out  1  the resolved prediction was correct
- miss_address  out  32  correct next PC when a prediction misses
- miss_count  out  MISS_CNT_W  saturating count of mispredictions

Behaviour:
- Reset (sync, highest priority):
  - D and E slots invalid, all fields 0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - miss_count = 0.
  - Consequently branch_sig = 0, hit = 0, miss_address = 0.
  - Reset asserted mid-operation discards in-flight branches with no resolution emitted.
- Slots: D (ID) and E (EX), each holding {valid, is_branch, pc, target, prediction}.
- Edge update, when stall=0:
  - E <= D.
  - D <= IF fields, with valid = if_valid & ~if_flush.
- Edge update, when stall=1:
  - D and E hold.
  - if_flush is ignored.
- Resolution (combinational from E plus operands):
  - eq = (ex_rs_data == ex_rt_data).
  - actual = ex_branch_type ? ~eq : eq.
  - branch_sig = E.valid & E.is_branch & ~stall.
  - hit = branch_sig & (actual == E.prediction).
  - miss_address = actual ? E.target : E.pc + 1 (32-bit wrap; 0xFFFFFFFF+1 = 0).
  - miss_address = 0 when branch_sig = 0.
- Misprediction (branch_sig & ~hit), at the edge:
  - D and E are invalidated (wrong path).
  - The IF entry presented that cycle is dropped.
  - This overrides the normal shift.
- BHT update on every branch_sig at the edge, at index E.pc[BHT_IDX_W-1:0]:
  - taken: increment, saturating at 3.
  - not taken: decrement, saturating at 0.
- miss_count increments on each misprediction and saturates at all-ones.
- lookup_taken is a combinational read. When it reads the same index being updated that cycle, it returns the pre-update value (no bypass).
- Non-branch E entries never assert branch_sig and never touch the BHT.
- Latency:
  - IF entry reaches E two unstalled edges after capture.
  - The verdict is visible in the same cycle E is valid.
  - The BHT update is visible on lookup_taken the next cycle.

Test Plan:
- Reset, then lookup_pc = 0..63 -> lookup_taken = 0 for every index; miss_count = 0; branch_sig = 0.
- Branch at pc=0x10, target=0x40, pred=0, beq with rs=rt=5 after 2 edges:
  - branch_sig = 1, hit = 0, miss_address = 0x40.
  - Next cycle: D/E invalid, miss_count = 1, lookup_taken(0x10) = 1.
- Branch at pc=0x20, pred=1, bne with rs=rt=7:
  - hit = 0, miss_address = 0x21.
  - BHT[0x20] goes 01 -> 00; four more not-taken branches keep it at 00.
- Correct prediction (pc=0x08, pred=0, beq with rs=1, rt=2):
  - branch_sig = 1, hit = 1, miss_address = 0x09.
  - No flush; the following D entry advances to E; miss_count unchanged.
- stall = 1 for 3 cycles while a branch sits in E:
  - branch_sig = 0 throughout.
  - On release exactly one resolution occurs, with one BHT update and at most one miss_count increment.
- Edge cases:
  - if_flush = 1 with if_is_branch = 1 -> that branch never resolves.
  - pc = 0xFFFFFFFF, not taken, pred = 1 -> miss_address = 0x00000000.
  - reset asserted while E holds a branch -> no branch_sig on the following cycle.
